seq_divider: RTL and testbench

Iterative radix-2 restoring divider: the sequential, parameterised successor to the combinational `param_divider`. It accepts one dividend/divisor pair through a valid/ready handshake and produces one quotient bit per clock. It returns quotient, remainder and a divide-by-zero flag through a second valid/ready handshake. It sits in the datapath wherever a full-width combinational divider would break timing, and optionally handles two's-complement operands.

---
 rtl/seq_divider_pkg.sv | 39 +++
 rtl/seq_divider.sv | 152 +++++++++++++++
 tb/tb_seq_divider.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/seq_divider_pkg.sv
// Shared types and width-generic helpers for the iterative restoring divider.
package seq_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Helpers operate on a 64-bit container; callers pass their real width.
    localparam int unsigned MAX_W = 64;

    function automatic logic [MAX_W-1:0] width_mask(input int unsigned w);
        logic [MAX_W-1:0] m;
        if (w >= MAX_W) begin
            m = '1;
        end else begin
            m = ~({MAX_W{1'b1}} << w);
        end
        return m;
    endfunction

    function automatic logic [MAX_W-1:0] neg_val(input logic [MAX_W-1:0] x,
                                                 input int unsigned     w);
        return (~x + MAX_W'(1)) & width_mask(w);
    endfunction

    function automatic logic [MAX_W-1:0] abs_val(input logic [MAX_W-1:0] x,
                                                 input int unsigned     w,
                                                 input logic            is_signed);
        logic sign;
        sign = ((x >> (w - 1)) & MAX_W'(1)) != '0;
        if (is_signed && sign) begin
            return neg_val(x, w);
        end
        return x & width_mask(w);
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Radix-2 restoring divider: one quotient bit per clock, valid/ready on both
// sides, optional two's-complement operands truncated toward zero.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned     CW        = $clog2(WIDTH);
    localparam logic [CW-1:0]   CNT_INIT  = CW'(WIDTH - 1);
    localparam logic            IS_SIGNED = (SIGNED != 0);

    div_state_t       state;
    div_state_t       state_nxt;

    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] dvsr;
    logic [CW-1:0]    cnt;
    logic             neg_q;
    logic             neg_r;
    logic             dz;

    logic             accept;
    logic             zero_div;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;
    logic             step_ok;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] q_step;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                if (cnt == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign zero_div = (divisor == '0);

    // Restoring step on {rem, q}; trial subtract carries one extra bit for the borrow.
    always_comb begin
        rem_sh   = {rem, q[WIDTH-1]};
        trial    = rem_sh - {1'b0, dvsr};
        step_ok  = ~trial[WIDTH];
        rem_step = step_ok ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        q_step   = {q[WIDTH-2:0], step_ok};
        q_fix    = neg_q ? WIDTH'(neg_val(MAX_W'(q_step), WIDTH)) : q_step;
        r_fix    = neg_r ? WIDTH'(neg_val(MAX_W'(rem_step), WIDTH)) : rem_step;
    end

    // A zero divisor still spends one cycle in CALC so its result appears one
    // edge after acceptance; that cycle just publishes the preloaded values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem         <= '0;
            q           <= '0;
            dvsr        <= '0;
            cnt         <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dz          <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        dz   <= zero_div;
                        dvsr <= WIDTH'(abs_val(MAX_W'(divisor), WIDTH, IS_SIGNED));
                        if (zero_div) begin
                            rem   <= dividend;
                            q     <= '1;
                            cnt   <= '0;
                            neg_q <= 1'b0;
                            neg_r <= 1'b0;
                        end else begin
                            rem   <= '0;
                            q     <= WIDTH'(abs_val(MAX_W'(dividend), WIDTH, IS_SIGNED));
                            cnt   <= CNT_INIT;
                            neg_q <= IS_SIGNED && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                            neg_r <= IS_SIGNED && dividend[WIDTH-1];
                        end
                    end
                end
                CALC: begin
                    if (dz) begin
                        quotient    <= q;
                        remainder   <= rem;
                        div_by_zero <= 1'b1;
                    end else begin
                        rem <= rem_step;
                        q   <= q_step;
                        cnt <= cnt - CW'(1);
                        if (cnt == '0) begin
                            quotient    <= q_fix;
                            remainder   <= r_fix;
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: one unsigned and one signed instance, WIDTH=8.
module tb_seq_divider;

    typedef struct packed {
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
        int         lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] dividend = '0;
    logic [7:0] divisor  = '0;
    logic       out_ready = 1'b0;
    logic       u_in_valid = 1'b0;
    logic       s_in_valid = 1'b0;
    logic       u_in_ready, s_in_ready, u_out_valid, s_out_valid, u_dbz, s_dbz;
    logic [7:0] u_q, u_r, s_q, s_r;

    logic       sel = 1'b0;
    logic       cur_in_ready, cur_out_valid, cur_dbz;
    logic [7:0] cur_q, cur_r;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_pass   = 0;

    always #5 clk = ~clk;

    seq_divider #(.WIDTH(8), .SIGNED(0)) u_dut (
        .clk(clk), .rst(rst), .in_valid(u_in_valid), .in_ready(u_in_ready),
        .dividend(dividend), .divisor(divisor), .out_valid(u_out_valid),
        .out_ready(out_ready), .quotient(u_q), .remainder(u_r), .div_by_zero(u_dbz)
    );

    seq_divider #(.WIDTH(8), .SIGNED(1)) s_dut (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .dividend(dividend), .divisor(divisor), .out_valid(s_out_valid),
        .out_ready(out_ready), .quotient(s_q), .remainder(s_r), .div_by_zero(s_dbz)
    );

    assign cur_in_ready  = sel ? s_in_ready  : u_in_ready;
    assign cur_out_valid = sel ? s_out_valid : u_out_valid;
    assign cur_q         = sel ? s_q         : u_q;
    assign cur_r         = sel ? s_r         : u_r;
    assign cur_dbz       = sel ? s_dbz       : u_dbz;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic s, input logic [7:0] dd, input logic [7:0] ds);
        exp_t e;
        int   a, b;
        if (ds == 8'd0) begin
            e.q = 8'hFF; e.r = dd; e.dbz = 1'b1; e.lat = 1;
        end else if (s) begin
            a = int'($signed(dd));
            b = int'($signed(ds));
            e.q = 8'(a / b); e.r = 8'(a % b); e.dbz = 1'b0; e.lat = 8;
        end else begin
            e.q = dd / ds; e.r = dd % ds; e.dbz = 1'b0; e.lat = 8;
        end
        return e;
    endfunction

    task automatic set_valid(input logic v);
        if (sel) s_in_valid = v;
        else     u_in_valid = v;
    endtask

    task automatic run_op(input logic s, input logic [7:0] dd, input logic [7:0] ds,
                          input int hold, input logic poke, input logic chk_gap);
        exp_t e;
        int   waits;
        int   lat;
        sel = s;
        sb.push_back(model(s, dd, ds));
        waits = 0;
        while (!cur_in_ready && waits < 40) begin
            @(posedge clk); #1;
            waits++;
        end
        if (!cur_in_ready) chk("in_ready_timeout", 32'(cur_in_ready), 32'(1));
        if (chk_gap) chk("accept_gap", 32'(waits), 32'(0));
        dividend = dd;
        divisor  = ds;
        set_valid(1'b1);
        @(posedge clk); #1;
        set_valid(1'b0);
        lat = 0;
        while (!cur_out_valid && lat < 40) begin
            if (poke && lat == 2) begin
                chk("calc_in_ready", 32'(cur_in_ready), 32'(0));
                dividend = 8'd1;
                divisor  = 8'd1;
                set_valid(1'b1);
            end
            if (poke && lat == 4) set_valid(1'b0);
            @(posedge clk); #1;
            lat++;
        end
        set_valid(1'b0);
        e = sb.pop_front();
        chk("out_valid", 32'(cur_out_valid), 32'(1));
        chk("latency", 32'(lat), 32'(e.lat));
        chk("quotient", 32'(cur_q), 32'(e.q));
        chk("remainder", 32'(cur_r), 32'(e.r));
        chk("div_by_zero", 32'(cur_dbz), 32'(e.dbz));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(cur_out_valid), 32'(1));
            chk("hold_in_ready", 32'(cur_in_ready), 32'(0));
            chk("hold_q", 32'(cur_q), 32'(e.q));
            chk("hold_r", 32'(cur_r), 32'(e.r));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("release_in_ready", 32'(cur_in_ready), 32'(1));
        chk("release_out_valid", 32'(cur_out_valid), 32'(0));
    endtask

    initial begin
        #1;
        chk("rst_in_ready", 32'(u_in_ready), 32'(1));
        chk("rst_out_valid", 32'(u_out_valid), 32'(0));
        chk("rst_q", 32'(u_q), 32'(0));
        chk("rst_r", 32'(u_r), 32'(0));
        chk("rst_dbz", 32'(u_dbz), 32'(0));
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(1'b0, 8'd15,  8'd3,   0, 1'b0, 1'b0);
        run_op(1'b0, 8'd255, 8'd1,   0, 1'b0, 1'b0);
        run_op(1'b0, 8'd0,   8'd255, 0, 1'b0, 1'b0);
        run_op(1'b0, 8'd200, 8'd7,   0, 1'b0, 1'b0);
        run_op(1'b0, 8'd37,  8'd0,   0, 1'b0, 1'b0);

        run_op(1'b1, 8'hF9,  8'd2,   0, 1'b0, 1'b0);
        run_op(1'b1, 8'd7,   8'hFE,  0, 1'b0, 1'b0);
        run_op(1'b1, 8'h80,  8'hFF,  0, 1'b0, 1'b0);
        run_op(1'b1, 8'hDB,  8'd0,   0, 1'b0, 1'b0);

        run_op(1'b0, 8'd100, 8'd9,   5, 1'b1, 1'b0);
        run_op(1'b0, 8'd77,  8'd5,   0, 1'b0, 1'b1);
        chk("sb_empty", 32'(sb.size()), 32'(0));

        sel = 1'b0;
        dividend = 8'd100;
        divisor  = 8'd9;
        u_in_valid = 1'b1;
        @(posedge clk); #1;
        u_in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("calc_before_rst", 32'(u_in_ready), 32'(0));
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(u_out_valid), 32'(0));
        chk("midrst_in_ready", 32'(u_in_ready), 32'(1));
        @(posedge clk); #1;
        rst = 1'b0;
        run_op(1'b0, 8'd50, 8'd6, 0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
